// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction-fetch and data requesters.
// Every grant runs a burst-aligned, fixed-length burst of BURST_LEN beats.
//
// state  | meaning
// IDLE   | no owner; requests sampled here only
// BUSY_I | instruction burst in progress
// BUSY_D | data burst in progress
// DONE   | one-cycle done pulse to owner; last_grant updated
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant_out
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = $clog2(BURST_LEN * BYTES);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [ADDR_W-1:0] BEAT_STEP  = ADDR_W'(BYTES);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic                we_q, we_d;
    logic                own_d_q, own_d_d;     // 1 = data port owns the burst
    logic                last_d_q, last_d_d;   // 1 = last completed grant was data
    logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;
    logic                i_rvalid_q, d_rvalid_q;
    logic                busy, rd_ack, pick_d;

    assign busy   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign rd_ack = busy && mem_ack && !we_q;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        base_d   = base_q;
        we_d     = we_q;
        own_d_d  = own_d_q;
        last_d_d = last_d_q;
        pick_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // Under contention, hand the port to whoever did not have it last.
                    pick_d  = d_req && (!i_req || !last_d_q);
                    state_d = pick_d ? BUSY_D : BUSY_I;
                    own_d_d = pick_d;
                    base_d  = (pick_d ? d_addr : i_addr) & ALIGN_MASK;
                    we_d    = pick_d && d_we;
                    beat_d  = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                last_d_d = own_d_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            base_q     <= '0;
            we_q       <= 1'b0;
            own_d_q    <= 1'b0;
            last_d_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            base_q     <= base_d;
            we_q       <= we_d;
            own_d_q    <= own_d_d;
            last_d_q   <= last_d_d;
            i_rvalid_q <= rd_ack && !own_d_q;
            d_rvalid_q <= rd_ack && own_d_q;
            if (rd_ack && !own_d_q) i_rdata_q <= mem_rdata;
            if (rd_ack && own_d_q)  d_rdata_q <= mem_rdata;
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = busy ? (base_q + ADDR_W'(beat_q) * BEAT_STEP) : '0;
    assign mem_wdata = (state_q == BUSY_D && we_q) ? d_wdata : '0;
    assign d_wready  = (state_q == BUSY_D) && we_q && mem_ack;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_done    = (state_q == DONE) && !own_d_q;
    assign d_done    = (state_q == DONE) && own_d_q;
    assign grant_out = (state_q == IDLE) ? 2'b00 : (own_d_q ? 2'b10 : 2'b01);

endmodule
